// File: rtl/adder_word_pkg.sv
// -----------------------------------------------------------------------------
// adder_word_pkg
// Shared constants for the adder_word carry-lookahead adder slice.
//   GROUP_W   : width of one first-level lookahead group (adder_cla4)
//   MIN_WIDTH : smallest legal operand width for adder_word
// adder_word's WIDTH must be a multiple of GROUP_W and at least MIN_WIDTH.
// -----------------------------------------------------------------------------
package adder_word_pkg;

    localparam int GROUP_W   = 4;
    localparam int MIN_WIDTH = GROUP_W;

endpackage : adder_word_pkg

// File: rtl/adder_word_cla4.sv
// -----------------------------------------------------------------------------
// adder_cla4
// 4-bit carry-lookahead group. All internal carries come from the lookahead
// equations of the group's bit-level propagate/generate terms, so nothing
// ripples inside the group.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry into bit 0 of the group
//   sum   : 4-bit group sum
//   pg    : group propagate (a carry into the group passes straight through)
//   gg    : group generate  (the group produces a carry-out on its own)
// -----------------------------------------------------------------------------
module adder_cla4
    import adder_word_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               pg,
    output logic               gg
);

    logic [GROUP_W-1:0] p;
    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

    // Group terms feed the second lookahead level in adder_word; the group's
    // own carry-out is produced there, not here.
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule : adder_cla4

// File: rtl/adder_word.sv
// -----------------------------------------------------------------------------
// adder_word
// Two-level carry-lookahead adder: WIDTH/4 adder_cla4 groups, with the
// inter-group carries computed by a second lookahead level from the group
// propagate/generate terms. Combinational results are also captured in an
// output register stage with asynchronous active-low reset.
// Parameter:
//   WIDTH        : operand/result width, multiple of 4, minimum 4 (default 32)
// Ports:
//   clk          : clock, registered outputs update on the rising edge
//   rst_n        : asynchronous active-low reset of the registered outputs only
//   a, b         : operands (unsigned or two's complement)
//   carry_in     : carry into bit 0
//   sum          : combinational low WIDTH bits of a + b + carry_in
//   carry_out    : combinational carry out of bit WIDTH-1
//   overflow     : combinational two's-complement overflow flag
//   sum_q        : registered sum
//   carry_out_q  : registered carry_out
//   overflow_q   : registered overflow
// -----------------------------------------------------------------------------
module adder_word
    import adder_word_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q,
    output logic             overflow_q
);

    localparam int NG = WIDTH / GROUP_W;

    logic [NG-1:0] grp_p;
    logic [NG-1:0] grp_g;
    logic [NG:0]   grp_c;

    // First lookahead level: one 4-bit group per nibble.
    for (genvar gi = 0; gi < NG; gi++) begin : g_group
        adder_cla4 u_cla4 (
            .a   (a[gi*GROUP_W +: GROUP_W]),
            .b   (b[gi*GROUP_W +: GROUP_W]),
            .cin (grp_c[gi]),
            .sum (sum[gi*GROUP_W +: GROUP_W]),
            .pg  (grp_p[gi]),
            .gg  (grp_g[gi])
        );
    end

    // Second lookahead level: each group carry is expanded as a flat
    // sum-of-products of group generate/propagate terms and carry_in,
    //   c[i+1] = G[i] | P[i]G[i-1] | ... | P[i]..P[1]G[0] | P[i]..P[0]cin
    // so no group waits on the carry of its neighbour.
    always_comb begin : lookahead
        logic term;
        logic prod;
        logic acc;
        grp_c    = '0;
        grp_c[0] = carry_in;
        for (int i = 0; i < NG; i++) begin
            term = carry_in;
            for (int k = 0; k <= i; k++) begin
                term = term & grp_p[k];
            end
            acc = term;
            for (int j = 0; j <= i; j++) begin
                prod = grp_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & grp_p[k];
                end
                acc = acc | prod;
            end
            grp_c[i+1] = acc;
        end
    end

    assign carry_out = grp_c[NG];

    // Signed overflow: operands share a sign that the result does not.
    assign overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sum_q       <= sum;
            carry_out_q <= carry_out;
            overflow_q  <= overflow;
        end
    end

endmodule : adder_word

// File: tb/tb_adder_word.sv
// -----------------------------------------------------------------------------
// tb_adder_word
// Self-checking bench for adder_word (WIDTH = 32). Expected values come from
// plain integer arithmetic: a 33-bit unsigned add for {carry_out, sum} and a
// signed 64-bit add range check for overflow.
// -----------------------------------------------------------------------------
module tb_adder_word;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic [W-1:0] sum_q;
    logic         carry_out_q;
    logic         overflow_q;

    int checks = 0;
    int errors = 0;

    adder_word #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .sum         (sum),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .sum_q       (sum_q),
        .carry_out_q (carry_out_q),
        .overflow_q  (overflow_q)
    );

    always #5 clk = ~clk;

    // Reference: full unsigned result of a + b + cin.
    function automatic logic [W:0] ref_full(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c);
        logic [W:0] r;
        r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return r;
    endfunction

    // Reference: true signed result falls outside the W-bit two's-complement range.
    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        longint s;
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    task automatic test_reset();
        #1 rst_n = 1'b0;
        a = 32'h1234_5678; b = 32'h0101_0101; carry_in = 1'b1;
        #1;
        checks++;
        if ({sum_q, carry_out_q, overflow_q} !== {{W{1'b0}}, 2'b00}) begin
            $display("FAIL reset_regs: got sum_q=%h co_q=%b ov_q=%b, want 0 0 0",
                     sum_q, carry_out_q, overflow_q);
            errors++;
        end
        checks++;
        if ({carry_out, sum} !== ref_full(a, b, carry_in)) begin
            $display("FAIL reset_comb: got %h, want %h", {carry_out, sum}, ref_full(a, b, carry_in));
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
        logic         tc [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [5] = '{32'h0000_0002, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic         eo [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            a = ta[i]; b = tb[i]; carry_in = tc[i];
            #1;
            checks++;
            if ({carry_out, sum, overflow} !== {ec[i], es[i], eo[i]}) begin
                $display("FAIL directed_%0d: got co=%b sum=%h ov=%b, want co=%b sum=%h ov=%b",
                         i, carry_out, sum, overflow, ec[i], es[i], eo[i]);
                errors++;
            end
        end
    endtask

    task automatic test_random_comb();
        for (int i = 0; i < 1024; i++) begin
            a = $urandom; b = $urandom; carry_in = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if ({carry_out, sum} !== ref_full(a, b, carry_in) ||
                overflow !== ref_ovf(a, b, carry_in)) begin
                $display("FAIL random_comb_%0d: a=%h b=%h cin=%b got co=%b sum=%h ov=%b, want %h ov=%b",
                         i, a, b, carry_in, carry_out, sum, overflow,
                         ref_full(a, b, carry_in), ref_ovf(a, b, carry_in));
                errors++;
                break;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] ef;
        logic       eo;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; carry_in = 1'($urandom_range(0, 1));
            if (i % 8 == 3) begin a = 32'h7FFF_FFF0; b = 32'h0000_0010; end
            ef = ref_full(a, b, carry_in);
            eo = ref_ovf(a, b, carry_in);
            @(posedge clk);
            #1;
            checks++;
            if ({carry_out_q, sum_q, overflow_q} !== {ef, eo}) begin
                $display("FAIL back_to_back_%0d: got co_q=%b sum_q=%h ov_q=%b, want %h ov=%b",
                         i, carry_out_q, sum_q, overflow_q, ef, eo);
                errors++;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 32'd5; b = 32'd3; carry_in = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sum_q !== 32'd9 || carry_out_q !== 1'b0) begin
            $display("FAIL reg_capture: got sum_q=%h co_q=%b, want 9 0", sum_q, carry_out_q);
            errors++;
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_q, carry_out_q, overflow_q} !== {{W{1'b0}}, 2'b00} || sum !== 32'd9) begin
            $display("FAIL async_reset: got sum_q=%h co_q=%b ov_q=%b sum=%h, want 0 0 0 9",
                     sum_q, carry_out_q, overflow_q, sum);
            errors++;
        end
    endtask

    task automatic test_reset_hold();
        logic [W:0] ef;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; carry_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checks++;
            if ({sum_q, carry_out_q, overflow_q} !== {{W{1'b0}}, 2'b00}) begin
                $display("FAIL reset_hold_%0d: got sum_q=%h co_q=%b ov_q=%b, want 0 0 0",
                         i, sum_q, carry_out_q, overflow_q);
                errors++;
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'h8000_0001; b = 32'h8000_0002; carry_in = 1'b0;
        ef = ref_full(a, b, carry_in);
        @(posedge clk);
        #1;
        checks++;
        if ({carry_out_q, sum_q, overflow_q} !== {ef, ref_ovf(a, b, carry_in)}) begin
            $display("FAIL reset_release: got co_q=%b sum_q=%h ov_q=%b, want %h ov=%b",
                     carry_out_q, sum_q, overflow_q, ef, ref_ovf(a, b, carry_in));
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_comb();
        test_back_to_back();
        test_async_reset();
        test_reset_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_adder_word
